// File: rtl/calc_sequencer.sv
// Front-panel sequencer: button pulses edit A/B/OP, launch the ALU with a timeout,
// capture the result and drive the 7-segment value/field selection.
module calc_sequencer #(
   parameter int WIDTH   = 4,
   parameter int OP_W    = 3,
   parameter int TIMEOUT = 15
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             up_i,
   input  logic             down_i,
   input  logic             enter_i,
   input  logic             back_i,
   input  logic [WIDTH-1:0] alu_result_i,
   input  logic             alu_done_i,
   output logic [WIDTH-1:0] alu_a_o,
   output logic [WIDTH-1:0] alu_b_o,
   output logic [OP_W-1:0]  alu_op_o,
   output logic             alu_start_o,
   output logic [WIDTH-1:0] disp_val_o,
   output logic [1:0]       disp_field_o,
   output logic             busy_o,
   output logic             err_o
);

   typedef enum logic [2:0] {S_A, S_B, S_OP, S_EXEC, S_RES} state_t;

   localparam logic [7:0] TO = 8'(TIMEOUT);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
   logic [OP_W-1:0]  op_q, op_d;
   logic [7:0]       cnt_q, cnt_d;
   logic             err_q, err_d;
   logic             start_q, start_d, busy_q, busy_d;
   logic [WIDTH-1:0] val_q, val_d;
   logic [1:0]       field_q, field_d;
   logic             inc, dec;

   // up and down together cancel each other
   assign inc = up_i & ~down_i;
   assign dec = down_i & ~up_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_A;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         res_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         start_q <= 1'b0;
         busy_q  <= 1'b0;
         val_q   <= '0;
         field_q <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         res_q   <= res_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         start_q <= start_d;
         busy_q  <= busy_d;
         val_q   <= val_d;
         field_q <= field_d;
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      res_d   = res_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      case (state_q)
         S_A: begin
            if (back_i)       a_d = '0;
            else if (enter_i) state_d = S_B;
            else if (inc)     a_d = a_q + 1'b1;
            else if (dec)     a_d = a_q - 1'b1;
         end
         S_B: begin
            if (back_i)       state_d = S_A;
            else if (enter_i) state_d = S_OP;
            else if (inc)     b_d = b_q + 1'b1;
            else if (dec)     b_d = b_q - 1'b1;
         end
         S_OP: begin
            if (back_i)       state_d = S_B;
            else if (enter_i) begin
               state_d = S_EXEC;
               cnt_d   = '0;
            end
            else if (inc)     op_d = op_q + 1'b1;
            else if (dec)     op_d = op_q - 1'b1;
         end
         S_EXEC: begin
            cnt_d = cnt_q + 8'd1;
            // start_q marks the launch cycle, where alu_done is not trusted
            if (back_i) state_d = S_OP;
            else if (alu_done_i && !start_q) begin
               res_d   = alu_result_i;
               err_d   = 1'b0;
               state_d = S_RES;
            end else if (cnt_q == TO) begin
               res_d   = '0;
               err_d   = 1'b1;
               state_d = S_RES;
            end
         end
         S_RES: begin
            if (enter_i) begin
               a_d     = res_q;
               err_d   = 1'b0;
               state_d = S_A;
            end else if (back_i) begin
               err_d   = 1'b0;
               state_d = S_OP;
            end
         end
         default: state_d = S_A;
      endcase
   end

   always_comb begin
      start_d = (state_q == S_OP) && (state_d == S_EXEC);
      busy_d  = (state_d == S_EXEC);
      field_d = 2'd3;
      val_d   = '0;
      case (state_d)
         S_A:     begin field_d = 2'd0; val_d = a_d;         end
         S_B:     begin field_d = 2'd1; val_d = b_d;         end
         S_OP:    begin field_d = 2'd2; val_d = WIDTH'(op_d); end
         S_RES:   val_d = res_d;
         default: val_d = '0;
      endcase
   end

   assign alu_a_o      = a_q;
   assign alu_b_o      = b_q;
   assign alu_op_o     = op_q;
   assign alu_start_o  = start_q;
   assign busy_o       = busy_q;
   assign err_o        = err_q;
   assign disp_val_o   = val_q;
   assign disp_field_o = field_q;

endmodule

// File: doc/calc_sequencer.md
# calc_sequencer

Front-panel controller for the calculator datapath. Converts debounced single-cycle button pulses (up, down, enter, back) into operand A, operand B and opcode entry. Launches the ALU through a start/done handshake with a timeout, captures the result, and supplies the value and field code that the 7-segment display driver renders. It sits between the button conditioning logic and the ALU/display inside the calculator top level.

## Interface
- WIDTH, 4: operand/result width in bits
- OP_W, 3: opcode width; opcode wraps modulo 2^OP_W
- TIMEOUT, 15: max cycles to wait for alu_done after alu_start (1..255)

- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  one clock; reset is asynchronous and active-low
- up, down, enter, back  in  1 each  single-cycle button pulses, already synchronized/debounced
- alu_result  in  WIDTH  ALU output, valid when alu_done=1
- alu_done  in  1  ALU completion pulse
- alu_a, alu_b  out  WIDTH  registered operands to ALU
- alu_op  out  OP_W  registered opcode to ALU
- alu_start  out  1  one-cycle launch pulse
- disp_val  out  WIDTH  value for the display (opcode zero-extended)
- disp_field  out  2  0=A, 1=B, 2=OP, 3=RESULT
- busy  out  1  high while waiting on the ALU
- err  out  1  high in RES when the last operation timed out

## Operation
- States: S_A, S_B, S_OP (edit), S_EXEC, S_RES.
- Reset (async, rst_n=0): state S_A. All registers and outputs are 0: A, B, OP, result, timeout counter, alu_a/b/op, alu_start, disp_val, disp_field, busy, err.
- Button priority in one cycle: back > enter > up/down. If up and down are both high, neither has any effect.
- Edit states:
  - up increments the current field; down decrements it.
  - Wrap: A and B wrap (2^WIDTH-1)->0 on up and 0->(2^WIDTH-1) on down; OP wraps the same way at 2^OP_W.
  - enter: S_A->S_B, S_B->S_OP, S_OP->S_EXEC.
  - back: S_OP->S_B, S_B->S_A. In S_A, back clears A to 0.
- alu_a/alu_b/alu_op track the A/B/OP registers. They are frozen for the whole of S_EXEC.
- S_EXEC:
  - alu_start=1 for exactly the first cycle in the state. busy=1 throughout.
  - Timeout counter clears on entry and increments each cycle.
  - alu_done is ignored during the alu_start cycle. From the next cycle on, alu_done=1 latches alu_result, clears err, and moves to S_RES.
  - If alu_done has not arrived when the counter reaches TIMEOUT: result=0, err=1, move to S_RES.
  - back aborts to S_OP. result and err are unchanged, and an alu_done arriving in that same cycle is discarded.
  - up, down and enter are ignored.
- S_RES:
  - enter: A<=result, B and OP retained, go to S_A (chained calculation). err clears.
  - back: go to S_OP. err clears.
  - up/down ignored.
- Display mapping:
  - disp_field is 0/1/2 in S_A/S_B/S_OP, 3 in S_EXEC and S_RES.
  - disp_val shows the edited field; OP is zero-extended.
  - In S_EXEC, disp_val=0. In S_RES, disp_val=result.

## Timing
- All outputs are registered. Every button effect is visible on the clock edge after the pulse cycle.
- enter in S_OP at edge N: alu_start=1 and busy=1 during cycle N+1, alu_start=0 from N+2.
- alu_done at edge M (M ≥ start edge + 1): disp_val=result and disp_field=3 after edge M+1; busy=0 at the same time.
- Timeout: with no alu_done, S_RES and err=1 are reached TIMEOUT+1 cycles after the alu_start cycle.
- alu_done outside S_EXEC has no effect.
- rst_n asserted mid-S_EXEC clears alu_start/busy immediately (asynchronously). After release the block is in S_A with all zeros.
- Back-to-back button pulses on consecutive cycles are each honoured; there is no lockout.

## Test plan
- Reset, then up x3, enter, down x2 (B=14), enter, up x5 (OP=5), enter -> alu_a=3, alu_b=14, alu_op=5, single alu_start pulse, busy=1.
- Bench ALU returns alu_result=9 with alu_done 4 cycles after start -> disp_field=3, disp_val=9, err=0. Then enter -> S_A with disp_val=9, B=14 and OP=5 retained.
- Wrap checks:
  - A=15, up -> 0.
  - A=0, down -> 15.
  - OP=7, up -> 0.
  - up+down in the same cycle -> no change.
  - back in S_A -> A=0.
- Bench ALU never asserts done -> S_RES with disp_val=0 and err=1 exactly TIMEOUT+1 cycles after alu_start. Then back -> S_OP with err=0.
- back during S_EXEC in the same cycle as alu_done=1, alu_result=6 -> S_OP, previous result not overwritten, no further alu_start.
- rst_n low for one cycle while busy=1 -> all outputs 0 immediately. After release, up -> A=1 in S_A.
